decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 149 ++++++++++++++
 tb/tb_decode_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32IM decode stage: splits the instruction into fields, forms the sign-extended
// immediate and register-use flags, and inserts one bubble per load-use dependency.
module decode_stage #(
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  input  logic [WORD_SIZE-1:0] in_pc,
  output logic                 in_ready,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic [WORD_SIZE-1:0] out_immediate,
  output logic                 out_uses_rs1,
  output logic                 out_uses_rs2,
  output logic                 out_writes_rd,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] bubble_count
);

  localparam logic [6:0] OP_ALU     = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JUMP    = 7'b1101111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;

  logic [6:0]           dec_opcode;
  logic [4:0]           dec_rd;
  logic [4:0]           dec_rs1;
  logic [4:0]           dec_rs2;
  logic [31:0]          dec_imm;
  logic [WORD_SIZE-1:0] dec_imm_ext;
  logic                 dec_uses_rs1;
  logic                 dec_uses_rs2;
  logic                 dec_writes_rd;
  logic                 dec_illegal;
  logic                 hazard;

  assign dec_opcode  = in_instr[6:0];
  assign dec_rd      = in_instr[11:7];
  assign dec_rs1     = in_instr[19:15];
  assign dec_rs2     = in_instr[24:20];
  assign dec_imm_ext = WORD_SIZE'($signed(dec_imm));

  always_comb begin
    dec_imm       = '0;
    dec_uses_rs1  = 1'b0;
    dec_uses_rs2  = 1'b0;
    dec_writes_rd = 1'b0;
    dec_illegal   = 1'b0;
    case (dec_opcode)
      OP_ALU: begin
        dec_uses_rs1  = 1'b1;
        dec_uses_rs2  = 1'b1;
        dec_writes_rd = 1'b1;
      end
      OP_ALU_IMM, OP_LOAD, OP_JALR: begin
        dec_imm       = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_uses_rs1  = 1'b1;
        dec_writes_rd = 1'b1;
      end
      OP_STORE: begin
        dec_imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm       = {in_instr[31:12], 12'b0};
        dec_writes_rd = 1'b1;
      end
      OP_JUMP: begin
        dec_imm       = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
        dec_writes_rd = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // x0 is hardwired, so nothing downstream should treat it as a destination
    if (dec_rd == 5'd0) dec_writes_rd = 1'b0;
  end

  assign hazard = in_valid && out_valid && (out_opcode == OP_LOAD) && (out_rd != 5'd0) &&
                  ((dec_uses_rs1 && (dec_rs1 == out_rd)) ||
                   (dec_uses_rs2 && (dec_rs2 == out_rd)));

  assign in_ready = !stall && !hazard;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_immediate <= '0;
      out_uses_rs1  <= 1'b0;
      out_uses_rs2  <= 1'b0;
      out_writes_rd <= 1'b0;
      out_illegal   <= 1'b0;
      bubble_count  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (stall) begin
      out_valid <= out_valid;
    end else if (hazard) begin
      // bubble: the load stays visible in the field registers but is no longer valid
      out_valid <= 1'b0;
      if (bubble_count != {CNT_WIDTH{1'b1}}) bubble_count <= bubble_count + CNT_WIDTH'(1);
    end else begin
      out_valid     <= in_valid;
      out_pc        <= in_pc;
      out_opcode    <= dec_opcode;
      out_funct3    <= in_instr[14:12];
      out_funct7    <= in_instr[31:25];
      out_rs1       <= dec_rs1;
      out_rs2       <= dec_rs2;
      out_rd        <= dec_rd;
      out_immediate <= dec_imm_ext;
      out_uses_rs1  <= dec_uses_rs1;
      out_uses_rs2  <= dec_uses_rs2;
      out_writes_rd <= dec_writes_rd;
      out_illegal   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, immediates, load-use bubbles,
// stall/flush priority, illegal opcodes, asynchronous reset and counter saturation.
module tb_decode_stage;

  logic        aclk;
  logic        aresetn;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_immediate;
  logic        out_uses_rs1;
  logic        out_uses_rs2;
  logic        out_writes_rd;
  logic        out_illegal;
  logic [2:0]  bubble_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_BEQ   = 32'h02208E63; // beq  x1,x2,60
  localparam logic [31:0] I_ADDI  = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] I_LW    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_DEP   = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_DEP0  = 32'h00700333; // add  x6,x0,x7
  localparam logic [31:0] I_ILLEG = 32'h0000007F;

  decode_stage #(.WORD_SIZE(32), .CNT_WIDTH(3)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_immediate(out_immediate),
    .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal),
    .bubble_count(bubble_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  // advance one edge and sample 1ns later; one line per cycle
  task automatic tick();
    @(posedge aclk);
    #1;
    $display("t=%0t valid=%0b pc=%h op=%b rd=%0d rs1=%0d rs2=%0d imm=%h bubbles=%0d",
             $time, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_immediate, bubble_count);
  endtask

  task automatic test_reset();
    aresetn = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", out_valid); end
    checks++; if (bubble_count !== 3'd0) begin errors++; $display("FAIL reset_bubbles: got %0d exp 0", bubble_count); end
    checks++; if (out_opcode !== 7'd0 || out_immediate !== 32'd0) begin errors++; $display("FAIL reset_fields: got op=%b imm=%h exp 0", out_opcode, out_immediate); end
    tick(); tick();
    aresetn = 1'b1;
  endtask

  task automatic test_add();
    drive(1'b1, I_ADD, 32'h100);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b exp 1", out_valid); end
    checks++; if (out_opcode !== 7'b0110011 || out_rd !== 5'd3 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2)
      begin errors++; $display("FAIL add_fields: got op=%b rd=%0d rs1=%0d rs2=%0d exp 0110011/3/1/2", out_opcode, out_rd, out_rs1, out_rs2); end
    checks++; if (out_funct3 !== 3'd0 || out_funct7 !== 7'd0 || out_immediate !== 32'd0)
      begin errors++; $display("FAIL add_funct_imm: got f3=%0d f7=%0d imm=%h exp 0/0/0", out_funct3, out_funct7, out_immediate); end
    checks++; if (out_pc !== 32'h100 || out_writes_rd !== 1'b1)
      begin errors++; $display("FAIL add_pc_wr: got pc=%h wr=%0b exp 100/1", out_pc, out_writes_rd); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, I_BEQ, 32'h104);
    tick();
    checks++; if (out_immediate !== 32'd60 || out_uses_rs2 !== 1'b1 || out_writes_rd !== 1'b0)
      begin errors++; $display("FAIL beq: got imm=%0d rs2u=%0b wr=%0b exp 60/1/0", out_immediate, out_uses_rs2, out_writes_rd); end
    drive(1'b1, I_ADDI, 32'h108);
    tick();
    checks++; if (out_valid !== 1'b1 || out_immediate !== 32'hFFFFFFFF || out_rd !== 5'd1)
      begin errors++; $display("FAIL addi: got v=%0b imm=%h rd=%0d exp 1/ffffffff/1", out_valid, out_immediate, out_rd); end
    checks++; if (out_uses_rs2 !== 1'b0 || out_writes_rd !== 1'b1 || out_pc !== 32'h108)
      begin errors++; $display("FAIL addi_flags: got rs2u=%0b wr=%0b pc=%h exp 0/1/108", out_uses_rs2, out_writes_rd, out_pc); end
  endtask

  task automatic test_load_use();
    drive(1'b1, I_LW, 32'h200);
    tick();
    drive(1'b1, I_DEP, 32'h204);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_low: got %0b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || bubble_count !== 3'd1)
      begin errors++; $display("FAIL lu_bubble: got v=%0b cnt=%0d exp 0/1", out_valid, bubble_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_high: got %0b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_rs1 !== 5'd5 || out_pc !== 32'h204 || out_rd !== 5'd6)
      begin errors++; $display("FAIL lu_issue: got v=%0b rs1=%0d pc=%h rd=%0d exp 1/5/204/6", out_valid, out_rs1, out_pc, out_rd); end
    checks++; if (bubble_count !== 3'd1) begin errors++; $display("FAIL lu_count: got %0d exp 1", bubble_count); end
    drive(1'b1, I_LW0, 32'h208);
    tick();
    drive(1'b1, I_DEP0, 32'h20C);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_ready: got %0b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20C || bubble_count !== 3'd1)
      begin errors++; $display("FAIL lu_x0_issue: got v=%0b pc=%h cnt=%0d exp 1/20c/1", out_valid, out_pc, bubble_count); end
  endtask

  task automatic test_stall();
    drive(1'b1, I_ADDI, 32'h300);
    tick();
    stall = 1'b1;
    drive(1'b1, I_ADD, 32'h304);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %0b exp 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_opcode !== 7'b0010011 || out_immediate !== 32'hFFFFFFFF)
        begin errors++; $display("FAIL stall_hold[%0d]: got v=%0b pc=%h op=%b imm=%h exp 1/300/0010011/ffffffff", i, out_valid, out_pc, out_opcode, out_immediate); end
    end
    stall = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_opcode !== 7'b0110011 || out_rd !== 5'd3)
      begin errors++; $display("FAIL stall_release: got v=%0b pc=%h op=%b rd=%0d exp 1/304/0110011/3", out_valid, out_pc, out_opcode, out_rd); end
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, I_BEQ, 32'h400);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stall: got v=%0b exp 0", out_valid); end
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, I_BEQ, 32'h400);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got v=%0b exp 0", out_valid); end
    // flush coinciding with a load-use hazard: no bubble counted
    drive(1'b1, I_LW, 32'h410);
    tick();
    flush = 1'b1;
    drive(1'b1, I_DEP, 32'h414);
    tick();
    checks++; if (out_valid !== 1'b0 || bubble_count !== 3'd1)
      begin errors++; $display("FAIL flush_hazard: got v=%0b cnt=%0d exp 0/1", out_valid, bubble_count); end
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hazard_drop: got v=%0b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    drive(1'b1, I_ILLEG, 32'h500);
    tick();
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1)
      begin errors++; $display("FAIL illegal: got v=%0b ill=%0b exp 1/1", out_valid, out_illegal); end
    checks++; if (out_uses_rs1 !== 1'b0 || out_uses_rs2 !== 1'b0 || out_writes_rd !== 1'b0 || out_immediate !== 32'd0)
      begin errors++; $display("FAIL illegal_flags: got u1=%0b u2=%0b wr=%0b imm=%h exp 0/0/0/0", out_uses_rs1, out_uses_rs2, out_writes_rd, out_immediate); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, I_LW, 32'h600);
    tick();
    drive(1'b1, I_DEP, 32'h604);
    tick();
    checks++; if (out_valid !== 1'b0 || bubble_count !== 3'd2)
      begin errors++; $display("FAIL rst_pre_bubble: got v=%0b cnt=%0d exp 0/2", out_valid, bubble_count); end
    #1;
    aresetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || bubble_count !== 3'd0 || out_opcode !== 7'd0 || out_rd !== 5'd0)
      begin errors++; $display("FAIL rst_async: got v=%0b cnt=%0d op=%b rd=%0d exp 0/0/0/0", out_valid, bubble_count, out_opcode, out_rd); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    aresetn = 1'b1;
    drive(1'b1, I_DEP, 32'h608);
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h608 || out_rs1 !== 5'd5 || bubble_count !== 3'd0)
      begin errors++; $display("FAIL rst_resume: got v=%0b pc=%h rs1=%0d cnt=%0d exp 1/608/5/0", out_valid, out_pc, out_rs1, bubble_count); end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, I_LW, 32'h700);
      tick();
      drive(1'b1, I_DEP, 32'h704);
      tick();
      exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
      checks++; if (bubble_count !== 3'(exp_cnt))
        begin errors++; $display("FAIL sat_count[%0d]: got %0d exp %0d", i, bubble_count, exp_cnt); end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_load_use();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
